// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Drives ALU operands, store data and destination register for the EX/MEM register.
module id_ex_operand_stage #(
    parameter int              WIDTH   = 32,
    parameter int              REGBITS = 5,
    parameter int              CTLW    = 4,
    parameter logic [CTLW-1:0] NOP_CTL = 4'b0010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Flush,
    input  logic [WIDTH-1:0]   ID_Data1,
    input  logic [WIDTH-1:0]   ID_Data2,
    input  logic [WIDTH-1:0]   ID_Imm,
    input  logic [REGBITS-1:0] ID_Rs,
    input  logic [REGBITS-1:0] ID_Rt,
    input  logic [REGBITS-1:0] ID_Rd,
    input  logic               ID_UsesRt,
    input  logic [CTLW-1:0]    ID_ALUCtl,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               EXMEM_RegWrite,
    input  logic [REGBITS-1:0] EXMEM_Rd,
    input  logic [WIDTH-1:0]   EXMEM_Result,
    input  logic               MEMWB_RegWrite,
    input  logic [REGBITS-1:0] MEMWB_Rd,
    input  logic [WIDTH-1:0]   MEMWB_Result,
    output logic [WIDTH-1:0]   ALU_Data1,
    output logic [WIDTH-1:0]   ALU_Data2,
    output logic [CTLW-1:0]    ALUCtl,
    output logic [WIDTH-1:0]   EX_StoreData,
    output logic [REGBITS-1:0] EX_WriteReg,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_Valid,
    output logic               LoadUse
);

    logic [WIDTH-1:0]   data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
    logic [REGBITS-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CTLW-1:0]    ctl_q, ctl_d;
    logic               alusrc_q, alusrc_d, regdst_q, regdst_d;
    logic               regwrite_q, regwrite_d, memread_q, memread_d;
    logic               memwrite_q, memwrite_d, valid_q, valid_d;
    logic [WIDTH-1:0]   fwd_rs, fwd_rt;

    // Newest producer wins; register $0 is hard-wired zero and never forwarded.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [REGBITS-1:0] r,
        input logic [WIDTH-1:0]   d,
        input logic               em_rw,
        input logic [REGBITS-1:0] em_rd,
        input logic [WIDTH-1:0]   em_res,
        input logic               mw_rw,
        input logic [REGBITS-1:0] mw_rd,
        input logic [WIDTH-1:0]   mw_res
    );
        if (em_rw && (em_rd != '0) && (em_rd == r))
            return em_res;
        else if (mw_rw && (mw_rd != '0) && (mw_rd == r))
            return mw_res;
        else
            return d;
    endfunction

    always_comb begin
        EX_WriteReg = regdst_q ? rd_q : rt_q;
        LoadUse = valid_q && memread_q && (EX_WriteReg != '0) &&
                  ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    end

    always_comb begin
        data1_d    = data1_q;
        data2_d    = data2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        ctl_d      = ctl_q;
        alusrc_d   = alusrc_q;
        regdst_d   = regdst_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        valid_d    = valid_q;
        if (Flush || (!Stall && LoadUse)) begin
            data1_d    = '0;
            data2_d    = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            ctl_d      = NOP_CTL;
            alusrc_d   = 1'b0;
            regdst_d   = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            valid_d    = 1'b0;
        end else if (!Stall) begin
            data1_d    = ID_Data1;
            data2_d    = ID_Data2;
            imm_d      = ID_Imm;
            rs_d       = ID_Rs;
            rt_d       = ID_Rt;
            rd_d       = ID_Rd;
            ctl_d      = ID_ALUCtl;
            alusrc_d   = ID_ALUSrc;
            regdst_d   = ID_RegDst;
            regwrite_d = ID_RegWrite;
            memread_d  = ID_MemRead;
            memwrite_d = ID_MemWrite;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q    <= '0;
            data2_q    <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            ctl_q      <= NOP_CTL;
            alusrc_q   <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            ctl_q      <= ctl_d;
            alusrc_q   <= alusrc_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        fwd_rs = fwd_sel(rs_q, data1_q, EXMEM_RegWrite, EXMEM_Rd, EXMEM_Result,
                         MEMWB_RegWrite, MEMWB_Rd, MEMWB_Result);
        fwd_rt = fwd_sel(rt_q, data2_q, EXMEM_RegWrite, EXMEM_Rd, EXMEM_Result,
                         MEMWB_RegWrite, MEMWB_Rd, MEMWB_Result);
        ALU_Data1    = fwd_rs;
        ALU_Data2    = alusrc_q ? imm_q : fwd_rt;
        EX_StoreData = fwd_rt;
        ALUCtl       = ctl_q;
        EX_RegWrite  = regwrite_q;
        EX_MemRead   = memread_q;
        EX_MemWrite  = memwrite_q;
        EX_Valid     = valid_q;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a cycle model pushes expected EX outputs
// when each ID word is driven; they are popped and compared after the clock edge.
module tb_id_ex_operand_stage;

    logic        clk, rst_n, Stall, Flush;
    logic [31:0] ID_Data1, ID_Data2, ID_Imm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_UsesRt, ID_ALUSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite;
    logic [3:0]  ID_ALUCtl;
    logic        EXMEM_RegWrite, MEMWB_RegWrite;
    logic [4:0]  EXMEM_Rd, MEMWB_Rd;
    logic [31:0] EXMEM_Result, MEMWB_Result;
    logic [31:0] ALU_Data1, ALU_Data2, EX_StoreData;
    logic [3:0]  ALUCtl;
    logic [4:0]  EX_WriteReg;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Valid, LoadUse;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
        .ID_Data1(ID_Data1), .ID_Data2(ID_Data2), .ID_Imm(ID_Imm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
        .ID_ALUCtl(ID_ALUCtl), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_Rd(EXMEM_Rd), .EXMEM_Result(EXMEM_Result),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_Rd(MEMWB_Rd), .MEMWB_Result(MEMWB_Result),
        .ALU_Data1(ALU_Data1), .ALU_Data2(ALU_Data2), .ALUCtl(ALUCtl),
        .EX_StoreData(EX_StoreData), .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_Valid(EX_Valid),
        .LoadUse(LoadUse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a1, a2, sd;
        logic [3:0]  ctl;
        logic [4:0]  wr;
        logic        rw, mr, mw, v;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic [31:0] m_d1, m_d2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [3:0]  m_ctl;
    logic        m_alusrc, m_regdst, m_rw, m_mr, m_mw, m_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_ctl = 4'b0010; m_alusrc = 0; m_regdst = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_v = 0;
    endtask

    task automatic model_load();
        m_d1 = ID_Data1; m_d2 = ID_Data2; m_imm = ID_Imm;
        m_rs = ID_Rs; m_rt = ID_Rt; m_rd = ID_Rd; m_ctl = ID_ALUCtl;
        m_alusrc = ID_ALUSrc; m_regdst = ID_RegDst; m_rw = ID_RegWrite;
        m_mr = ID_MemRead; m_mw = ID_MemWrite; m_v = 1'b1;
    endtask

    function automatic logic [31:0] fwd_m(input logic [4:0] r, input logic [31:0] d);
        if (EXMEM_RegWrite && EXMEM_Rd != 0 && EXMEM_Rd == r) return EXMEM_Result;
        if (MEMWB_RegWrite && MEMWB_Rd != 0 && MEMWB_Rd == r) return MEMWB_Result;
        return d;
    endfunction

    function automatic logic lu_m();
        logic [4:0] wr;
        wr = m_regdst ? m_rd : m_rt;
        return m_v && m_mr && (wr != 0) &&
               ((wr == ID_Rs) || (ID_UsesRt && (wr == ID_Rt)));
    endfunction

    task automatic push_exp();
        exp_t e;
        e.a1  = fwd_m(m_rs, m_d1);
        e.sd  = fwd_m(m_rt, m_d2);
        e.a2  = m_alusrc ? m_imm : e.sd;
        e.ctl = m_ctl;
        e.wr  = m_regdst ? m_rd : m_rt;
        e.rw  = m_rw; e.mr = m_mr; e.mw = m_mw; e.v = m_v;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, ":empty_q"}, 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, ":a1"},  ALU_Data1, e.a1);
        chk({tag, ":a2"},  ALU_Data2, e.a2);
        chk({tag, ":sd"},  EX_StoreData, e.sd);
        chk({tag, ":ctl"}, 32'(ALUCtl), 32'(e.ctl));
        chk({tag, ":wr"},  32'(EX_WriteReg), 32'(e.wr));
        chk({tag, ":rw"},  32'(EX_RegWrite), 32'(e.rw));
        chk({tag, ":mr"},  32'(EX_MemRead), 32'(e.mr));
        chk({tag, ":mw"},  32'(EX_MemWrite), 32'(e.mw));
        chk({tag, ":v"},   32'(EX_Valid), 32'(e.v));
    endtask

    // One clock: check LoadUse against the model, advance model, compare after the edge.
    task automatic step(input string tag);
        logic elu;
        @(negedge clk); #1;
        elu = lu_m();
        chk({tag, ":lu"}, 32'(LoadUse), 32'(elu));
        if (Flush || (!Stall && elu)) model_bubble();
        else if (!Stall) model_load();
        push_exp();
        @(posedge clk); #1;
        pop_cmp(tag);
    endtask

    task automatic set_id(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] ctl, input logic usesrt, input logic alusrc,
                          input logic regdst, input logic rw, input logic mr, input logic mw);
        ID_Data1 = d1; ID_Data2 = d2; ID_Imm = imm; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
        ID_ALUCtl = ctl; ID_UsesRt = usesrt; ID_ALUSrc = alusrc; ID_RegDst = regdst;
        ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw;
    endtask

    task automatic set_fwd(input logic emrw, input logic [4:0] emrd, input logic [31:0] emres,
                           input logic mwrw, input logic [4:0] mwrd, input logic [31:0] mwres);
        EXMEM_RegWrite = emrw; EXMEM_Rd = emrd; EXMEM_Result = emres;
        MEMWB_RegWrite = mwrw; MEMWB_Rd = mwrd; MEMWB_Result = mwres;
    endtask

    initial begin
        rst_n = 1'b0; Stall = 0; Flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_bubble();
        #12;
        push_exp();
        pop_cmp("por");
        chk("por:lu", 32'(LoadUse), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Async reset mid-cycle after real instructions are in flight
        set_id(32'h11, 32'h22, 32'h33, 5'd3, 5'd4, 5'd6, 4'h7, 1, 0, 1, 1, 1, 0);
        step("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_bubble();
        push_exp();
        pop_cmp("async_rst");
        chk("async_rst:lu", 32'(LoadUse), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Forwarding priority: EX/MEM beats MEM/WB, then MEM/WB alone
        set_id(32'h1, 32'h2, 32'h0, 5'd5, 5'd5, 5'd9, 4'h1, 1, 0, 1, 1, 0, 0);
        set_fwd(1, 5'd5, 32'hAAAA, 1, 5'd5, 32'hBBBB);
        step("fwd_em");
        chk("fwd_em:a1", ALU_Data1, 32'hAAAA);
        chk("fwd_em:a2", ALU_Data2, 32'hAAAA);
        Stall = 1; EXMEM_RegWrite = 0;
        step("fwd_mw");
        chk("fwd_mw:a1", ALU_Data1, 32'hBBBB);
        chk("fwd_mw:a2", ALU_Data2, 32'hBBBB);
        Stall = 0;

        // $0 guard
        set_id(32'h55, 32'h66, 32'h0, 5'd0, 5'd7, 5'd10, 4'h2, 1, 0, 1, 1, 0, 0);
        set_fwd(1, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
        step("zero_guard");
        chk("zero_guard:a1", ALU_Data1, 32'h55);

        // Load-use: lw $8, then add using $8 -> one bubble, then captured
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 4'h2, 0, 1, 0, 1, 1, 0);
        step("lw");
        set_id(32'h8, 32'h9, 32'h0, 5'd8, 5'd2, 5'd9, 4'h2, 1, 0, 1, 1, 0, 0);
        #1 chk("lu_hit", 32'(LoadUse), 32'd1);
        step("lu_bubble");
        chk("lu_bubble:v", 32'(EX_Valid), 32'd0);
        chk("lu_bubble:ctl", 32'(ALUCtl), 32'h2);
        step("lu_capture");
        chk("lu_capture:v", 32'(EX_Valid), 32'd1);

        // rt-only dependence matters only when the instruction reads rt; $0 load never stalls
        set_id(32'h100, 32'h0, 32'h4, 5'd1, 5'd12, 5'd0, 4'h2, 0, 1, 0, 1, 1, 0);
        step("lw2");
        set_id(32'h1, 32'h2, 32'h0, 5'd3, 5'd12, 5'd13, 4'h2, 0, 1, 0, 1, 0, 0);
        step("no_rt_use");
        set_id(32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 4'h2, 0, 1, 0, 1, 1, 0);
        step("lw_r0");
        set_id(32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd13, 4'h2, 1, 0, 1, 1, 0, 0);
        step("lw_r0_use");

        // Stall holds for 3 cycles despite new ID contents; Flush+Stall bubbles
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(32'hDEAD0000 + i, 32'hBEEF, 32'h7, 5'd14, 5'd15, 5'd16, 4'hF, 1, 1, 1, 0, 0, 1);
            step("stall");
        end
        Flush = 1;
        step("flush_stall");
        chk("flush_stall:v", 32'(EX_Valid), 32'd0);
        Flush = 0; Stall = 0;

        // ALUSrc: immediate to ALU, forwarded rt to store data
        set_id(32'h0, 32'h0, 32'hFFFFFFFC, 5'd2, 5'd3, 5'd0, 4'h2, 1, 1, 0, 0, 0, 1);
        set_fwd(1, 5'd3, 32'h10, 0, 0, 0);
        step("alusrc");
        chk("alusrc:a2", ALU_Data2, 32'hFFFFFFFC);
        chk("alusrc:sd", EX_StoreData, 32'h10);

        // Randomised traffic over a small register set to exercise hazards
        for (int i = 0; i < 300; i++) begin
            set_id($urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 4'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            Stall = ($urandom_range(0, 5) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
